// File: rtl/sat_bin_pkg.sv
// Shared encodings and packed entry layouts for one SAT bin load image.
// The engine imports the same struct typedefs so both sides agree on bit placement.
package sat_bin_pkg;

   localparam int SAT_NUM_CLAUSES = 8;
   localparam int SAT_NUM_VARS    = 8;
   localparam int SAT_NUM_LVLS    = 8;
   localparam int SAT_WIDTH_LVL   = 16;
   localparam int SAT_WIDTH_BIN   = 15;

   typedef enum logic [1:0] {
      LIT_NONE = 2'b00,
      LIT_POS  = 2'b01,
      LIT_NEG  = 2'b10
   } lit_t;

   typedef enum logic [1:0] {
      VAL_UNASSIGNED = 2'b00,
      VAL_TRUE       = 2'b01,
      VAL_FALSE      = 2'b10
   } val_t;

   typedef struct packed {
      logic [1:0]               value;
      logic                     implied;
      logic [SAT_WIDTH_LVL-1:0] level;
   } var_state_t;

   typedef struct packed {
      logic [SAT_WIDTH_BIN-1:0] dcd_bin;
      logic                     has_bkt;
   } lvl_state_t;

   // Code 3 has no meaning as a literal, so it collapses to "absent".
   function automatic logic [1:0] lit_store(input logic [1:0] code);
      logic [1:0] lit;
      case (code)
         LIT_POS: lit = LIT_POS;
         LIT_NEG: lit = LIT_NEG;
         default: lit = LIT_NONE;
      endcase
      return lit;
   endfunction

endpackage

// File: rtl/sat_bin_state_packer_if.sv
// Host-side bundle for the bin packer: clause, var-state and level-state
// write/read ports. The packer takes the slave view, the host the master view.
interface sat_bin_state_packer_if #(
   parameter int NUM_VARS         = 8,
   parameter int NUM_LVLS         = 8,
   parameter int WIDTH_LVL        = 16,
   parameter int WIDTH_BIN_ID     = 15,
   parameter int WIDTH_VAR_STATES = 3 + WIDTH_LVL,
   parameter int WIDTH_LVL_STATES = WIDTH_BIN_ID + 1
);
   logic                                 clr_i;
   logic                                 c_wr_i;
   logic [2:0]                           c_wr_row_i;
   logic [2:0]                           c_wr_var_i;
   logic [1:0]                           c_wr_lit_i;
   logic [2:0]                           c_rd_row_i;
   logic [NUM_VARS*2-1:0]                clause_o;

   logic                                 vs_wr_i;
   logic [2:0]                           vs_idx_i;
   logic [1:0]                           vs_value_i;
   logic                                 vs_implied_i;
   logic [WIDTH_LVL-1:0]                 vs_level_i;
   logic                                 vs_load_i;
   logic [WIDTH_VAR_STATES*NUM_VARS-1:0] var_states_i;
   logic [WIDTH_VAR_STATES*NUM_VARS-1:0] var_states_o;
   logic [2:0]                           vs_rd_idx_i;
   logic [1:0]                           vs_value_o;
   logic                                 vs_implied_o;
   logic [WIDTH_LVL-1:0]                 vs_level_o;

   logic                                 ls_wr_i;
   logic [2:0]                           ls_idx_i;
   logic [WIDTH_BIN_ID-1:0]              ls_dcd_bin_i;
   logic                                 ls_has_bkt_i;
   logic                                 ls_load_i;
   logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i;
   logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o;
   logic [2:0]                           ls_rd_idx_i;
   logic [WIDTH_BIN_ID-1:0]              ls_dcd_bin_o;
   logic                                 ls_has_bkt_o;

   modport master (
      output clr_i, c_wr_i, c_wr_row_i, c_wr_var_i, c_wr_lit_i, c_rd_row_i,
      output vs_wr_i, vs_idx_i, vs_value_i, vs_implied_i, vs_level_i,
      output vs_load_i, var_states_i, vs_rd_idx_i,
      output ls_wr_i, ls_idx_i, ls_dcd_bin_i, ls_has_bkt_i,
      output ls_load_i, lvl_states_i, ls_rd_idx_i,
      input  clause_o, var_states_o, vs_value_o, vs_implied_o, vs_level_o,
      input  lvl_states_o, ls_dcd_bin_o, ls_has_bkt_o
   );

   modport slave (
      input  clr_i, c_wr_i, c_wr_row_i, c_wr_var_i, c_wr_lit_i, c_rd_row_i,
      input  vs_wr_i, vs_idx_i, vs_value_i, vs_implied_i, vs_level_i,
      input  vs_load_i, var_states_i, vs_rd_idx_i,
      input  ls_wr_i, ls_idx_i, ls_dcd_bin_i, ls_has_bkt_i,
      input  ls_load_i, lvl_states_i, ls_rd_idx_i,
      output clause_o, var_states_o, vs_value_o, vs_implied_o, vs_level_o,
      output lvl_states_o, ls_dcd_bin_o, ls_has_bkt_o
   );

endinterface

// File: rtl/sat_bin_state_packer_state_list_reg.sv
// Indexed entry array with whole-list bus load, single-entry write and
// single-entry read; the packed bus view is the array itself.
module state_list_reg #(
   parameter int NUM   = 8,
   parameter int WIDTH = 19,
   parameter int IDX_W = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   load,
   input  logic [WIDTH*NUM-1:0]   bus_i,
   input  logic                   wr,
   input  logic [IDX_W-1:0]       wr_idx,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic [IDX_W-1:0]       rd_idx,
   output logic [WIDTH*NUM-1:0]   bus_o,
   output logic [WIDTH-1:0]       rd_data
);

   logic [NUM-1:0][WIDTH-1:0] mem;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         mem <= '0;
      end else if (load) begin
         mem <= bus_i;
      end else if (wr && (int'(wr_idx) < NUM)) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign bus_o = mem;

   always_comb begin
      rd_data = '0;
      if (int'(rd_idx) < NUM) begin
         rd_data = mem[rd_idx];
      end
   end

endmodule

// File: rtl/sat_bin_state_packer.sv
// One bin's load image for the SAT engine: clause array plus var/level state
// lists, exposed both as packed buses and as per-entry fields.
module sat_bin_state_packer
   import sat_bin_pkg::*;
#(
   parameter int NUM_CLAUSES      = 8,
   parameter int NUM_VARS         = 8,
   parameter int NUM_LVLS         = 8,
   parameter int WIDTH_LVL        = 16,
   parameter int WIDTH_BIN_ID     = 15,
   parameter int WIDTH_VAR_STATES = 3 + WIDTH_LVL,
   parameter int WIDTH_LVL_STATES = WIDTH_BIN_ID + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   sat_bin_state_packer_if.slave bus
);

   logic [NUM_CLAUSES-1:0][NUM_VARS-1:0][1:0] clauses;
   logic [WIDTH_VAR_STATES-1:0]               vs_wr_entry;
   logic [WIDTH_VAR_STATES-1:0]               vs_rd_entry;
   logic [WIDTH_LVL_STATES-1:0]               ls_wr_entry;
   logic [WIDTH_LVL_STATES-1:0]               ls_rd_entry;

   always_ff @(posedge clk) begin
      if (rst || bus.clr_i) begin
         clauses <= '0;
      end else if (bus.c_wr_i && (int'(bus.c_wr_row_i) < NUM_CLAUSES)
                   && (int'(bus.c_wr_var_i) < NUM_VARS)) begin
         clauses[bus.c_wr_row_i][bus.c_wr_var_i] <= lit_store(bus.c_wr_lit_i);
      end
   end

   always_comb begin
      bus.clause_o = '0;
      if (int'(bus.c_rd_row_i) < NUM_CLAUSES) begin
         bus.clause_o = clauses[bus.c_rd_row_i];
      end
   end

   // Value sits in the MSBs so the entry matches var_state_t bit for bit.
   assign vs_wr_entry = {bus.vs_value_i, bus.vs_implied_i, bus.vs_level_i};

   state_list_reg #(
      .NUM   (NUM_VARS),
      .WIDTH (WIDTH_VAR_STATES),
      .IDX_W (3)
   ) u_var_list (
      .clk     (clk),
      .rst     (rst),
      .clr     (bus.clr_i),
      .load    (bus.vs_load_i),
      .bus_i   (bus.var_states_i),
      .wr      (bus.vs_wr_i),
      .wr_idx  (bus.vs_idx_i),
      .wr_data (vs_wr_entry),
      .rd_idx  (bus.vs_rd_idx_i),
      .bus_o   (bus.var_states_o),
      .rd_data (vs_rd_entry)
   );

   assign bus.vs_level_o   = vs_rd_entry[WIDTH_LVL-1:0];
   assign bus.vs_implied_o = vs_rd_entry[WIDTH_LVL];
   assign bus.vs_value_o   = vs_rd_entry[WIDTH_LVL+2:WIDTH_LVL+1];

   assign ls_wr_entry = {bus.ls_dcd_bin_i, bus.ls_has_bkt_i};

   state_list_reg #(
      .NUM   (NUM_LVLS),
      .WIDTH (WIDTH_LVL_STATES),
      .IDX_W (3)
   ) u_lvl_list (
      .clk     (clk),
      .rst     (rst),
      .clr     (bus.clr_i),
      .load    (bus.ls_load_i),
      .bus_i   (bus.lvl_states_i),
      .wr      (bus.ls_wr_i),
      .wr_idx  (bus.ls_idx_i),
      .wr_data (ls_wr_entry),
      .rd_idx  (bus.ls_rd_idx_i),
      .bus_o   (bus.lvl_states_o),
      .rd_data (ls_rd_entry)
   );

   assign bus.ls_has_bkt_o = ls_rd_entry[0];
   assign bus.ls_dcd_bin_o = ls_rd_entry[WIDTH_BIN_ID:1];

endmodule

// File: tb/tb_sat_bin_state_packer.sv
// Directed plus randomized checks of the bin packer against an array model.
module tb_sat_bin_state_packer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   int cl [8][8];
   int vv [8];
   int vi [8];
   int vl [8];
   int lb [8];
   int lk [8];

   sat_bin_state_packer_if bus ();

   sat_bin_state_packer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [151:0] obs, input logic [151:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_zero();
      for (int r = 0; r < 8; r++) begin
         for (int j = 0; j < 8; j++) cl[r][j] = 0;
         vv[r] = 0; vi[r] = 0; vl[r] = 0; lb[r] = 0; lk[r] = 0;
      end
   endtask

   // Model reads only the stimulus the bench itself is driving.
   task automatic model_update();
      logic [151:0] vb;
      logic [127:0] lbus;
      if (rst || bus.clr_i) begin
         model_zero();
      end else begin
         if (bus.c_wr_i)
            cl[bus.c_wr_row_i][bus.c_wr_var_i] = (bus.c_wr_lit_i == 2'd3) ? 0 : int'(bus.c_wr_lit_i);
         if (bus.vs_load_i) begin
            vb = bus.var_states_i;
            for (int j = 0; j < 8; j++) begin
               vl[j] = int'((vb >> (19 * j)) & 152'hFFFF);
               vi[j] = int'((vb >> (19 * j + 16)) & 152'h1);
               vv[j] = int'((vb >> (19 * j + 17)) & 152'h3);
            end
         end else if (bus.vs_wr_i) begin
            vv[bus.vs_idx_i] = int'(bus.vs_value_i);
            vi[bus.vs_idx_i] = int'(bus.vs_implied_i);
            vl[bus.vs_idx_i] = int'(bus.vs_level_i);
         end
         if (bus.ls_load_i) begin
            lbus = bus.lvl_states_i;
            for (int k = 0; k < 8; k++) begin
               lk[k] = int'((lbus >> (16 * k)) & 128'h1);
               lb[k] = int'((lbus >> (16 * k + 1)) & 128'h7FFF);
            end
         end else if (bus.ls_wr_i) begin
            lb[bus.ls_idx_i] = int'(bus.ls_dcd_bin_i);
            lk[bus.ls_idx_i] = int'(bus.ls_has_bkt_i);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_update();
      bus.clr_i = 1'b0; bus.c_wr_i = 1'b0; bus.vs_wr_i = 1'b0;
      bus.vs_load_i = 1'b0; bus.ls_wr_i = 1'b0; bus.ls_load_i = 1'b0;
      #1;
   endtask

   function automatic logic [151:0] exp_clause(input int r);
      logic [151:0] e = '0;
      for (int j = 0; j < 8; j++) e = e + (152'(cl[r][j]) << (2 * j));
      return e;
   endfunction

   function automatic logic [151:0] exp_vs();
      logic [151:0] e = '0;
      for (int j = 0; j < 8; j++)
         e = e | ((152'(vv[j]) * 152'h20000 + 152'(vi[j]) * 152'h10000 + 152'(vl[j])) << (19 * j));
      return e;
   endfunction

   function automatic logic [151:0] exp_ls();
      logic [151:0] e = '0;
      for (int k = 0; k < 8; k++)
         e = e | ((152'(lb[k]) * 152'd2 + 152'(lk[k])) << (16 * k));
      return e;
   endfunction

   task automatic check_buses(input string tag);
      chk({tag, "_var_states"}, 152'(bus.var_states_o), exp_vs());
      chk({tag, "_lvl_states"}, 152'(bus.lvl_states_o), exp_ls());
   endtask

   task automatic check_row(input string tag, input int r);
      bus.c_rd_row_i = 3'(r);
      #1;
      chk($sformatf("%s_clause_row%0d", tag, r), 152'(bus.clause_o), exp_clause(r));
   endtask

   task automatic check_fields(input string tag, input int v, input int l);
      bus.vs_rd_idx_i = 3'(v);
      bus.ls_rd_idx_i = 3'(l);
      #1;
      chk($sformatf("%s_vs_value%0d", tag, v), 152'(bus.vs_value_o), 152'(vv[v]));
      chk($sformatf("%s_vs_implied%0d", tag, v), 152'(bus.vs_implied_o), 152'(vi[v]));
      chk($sformatf("%s_vs_level%0d", tag, v), 152'(bus.vs_level_o), 152'(vl[v]));
      chk($sformatf("%s_ls_bin%0d", tag, l), 152'(bus.ls_dcd_bin_o), 152'(lb[l]));
      chk($sformatf("%s_ls_bkt%0d", tag, l), 152'(bus.ls_has_bkt_o), 152'(lk[l]));
   endtask

   task automatic check_all(input string tag);
      check_buses(tag);
      for (int r = 0; r < 8; r++) check_row(tag, r);
      for (int i = 0; i < 8; i++) check_fields(tag, i, 7 - i);
   endtask

   function automatic logic [151:0] rand_vs_bus();
      logic [159:0] t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[151:0];
   endfunction

   initial begin
      logic [151:0] pat;
      logic [159:0] lpat;
      model_zero();
      bus.clr_i = 0; bus.c_wr_i = 0; bus.c_wr_row_i = 0; bus.c_wr_var_i = 0;
      bus.c_wr_lit_i = 0; bus.c_rd_row_i = 0;
      bus.vs_wr_i = 0; bus.vs_idx_i = 0; bus.vs_value_i = 0; bus.vs_implied_i = 0;
      bus.vs_level_i = 0; bus.vs_load_i = 0; bus.var_states_i = '0; bus.vs_rd_idx_i = 0;
      bus.ls_wr_i = 0; bus.ls_idx_i = 0; bus.ls_dcd_bin_i = 0; bus.ls_has_bkt_i = 0;
      bus.ls_load_i = 0; bus.lvl_states_i = '0; bus.ls_rd_idx_i = 0;

      tick(); tick();
      rst = 1'b0;
      #1;
      check_all("reset");

      // Row 0: var0 positive, var1 negative, var7 positive -> 16'h4009.
      bus.c_wr_i = 1; bus.c_wr_row_i = 0; bus.c_wr_var_i = 0; bus.c_wr_lit_i = 2'd1; tick();
      bus.c_wr_i = 1; bus.c_wr_row_i = 0; bus.c_wr_var_i = 1; bus.c_wr_lit_i = 2'd2; tick();
      bus.c_wr_i = 1; bus.c_wr_row_i = 0; bus.c_wr_var_i = 7; bus.c_wr_lit_i = 2'd1; tick();
      bus.c_rd_row_i = 0; #1;
      chk("clause_row0_const", 152'(bus.clause_o), 152'h4009);
      bus.c_rd_row_i = 1; #1;
      chk("clause_row1_const", 152'(bus.clause_o), 152'h0);
      // Code 3 collapses to absent.
      bus.c_wr_i = 1; bus.c_wr_row_i = 0; bus.c_wr_var_i = 1; bus.c_wr_lit_i = 2'd3; tick();
      bus.c_rd_row_i = 0; #1;
      chk("clause_lit3_const", 152'(bus.clause_o), 152'h4001);

      // vs entry 2 = {2'b10, 1'b1, 16'd3} = 19'h50003; ls entry 1 = {15'd5, 1'b1} = 16'h000B.
      bus.vs_wr_i = 1; bus.vs_idx_i = 2; bus.vs_value_i = 2; bus.vs_implied_i = 1; bus.vs_level_i = 3;
      bus.ls_wr_i = 1; bus.ls_idx_i = 1; bus.ls_dcd_bin_i = 5; bus.ls_has_bkt_i = 1;
      tick();
      chk("vs_entry2_const", 152'(bus.var_states_o), 152'h50003 << 38);
      chk("ls_entry1_const", 152'(bus.lvl_states_o), 152'h000B << 16);
      check_fields("fields_const", 2, 1);

      // Bus load wins over a same-cycle field write.
      pat = rand_vs_bus();
      bus.vs_load_i = 1; bus.var_states_i = pat;
      bus.vs_wr_i = 1; bus.vs_idx_i = 4; bus.vs_value_i = 1; bus.vs_implied_i = 1; bus.vs_level_i = 16'hBEEF;
      lpat = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      bus.ls_load_i = 1; bus.lvl_states_i = lpat[127:0];
      bus.ls_wr_i = 1; bus.ls_idx_i = 3; bus.ls_dcd_bin_i = 15'h1234; bus.ls_has_bkt_i = 1;
      tick();
      chk("vs_load_roundtrip", 152'(bus.var_states_o), pat);
      chk("ls_load_roundtrip", 152'(bus.lvl_states_o), 152'(lpat[127:0]));
      check_all("after_load");

      // Clear together with writes discards everything.
      for (int r = 0; r < 8; r++) begin
         bus.c_wr_i = 1; bus.c_wr_row_i = 3'(r); bus.c_wr_var_i = 3'(r); bus.c_wr_lit_i = 2'd2; tick();
      end
      bus.clr_i = 1; bus.c_wr_i = 1; bus.c_wr_row_i = 5; bus.c_wr_var_i = 5; bus.c_wr_lit_i = 1;
      bus.vs_wr_i = 1; bus.ls_wr_i = 1;
      tick();
      chk("clr_var_states_zero", 152'(bus.var_states_o), 152'h0);
      chk("clr_lvl_states_zero", 152'(bus.lvl_states_o), 152'h0);
      check_all("after_clr");

      for (int it = 0; it < 400; it++) begin
         bus.c_wr_i = 1'($urandom_range(0, 1));
         bus.c_wr_row_i = 3'($urandom); bus.c_wr_var_i = 3'($urandom); bus.c_wr_lit_i = 2'($urandom);
         bus.vs_wr_i = 1'($urandom_range(0, 1));
         bus.vs_idx_i = 3'($urandom); bus.vs_value_i = 2'($urandom);
         bus.vs_implied_i = 1'($urandom); bus.vs_level_i = 16'($urandom);
         bus.vs_load_i = ($urandom_range(0, 9) == 0);
         bus.var_states_i = rand_vs_bus();
         bus.ls_wr_i = 1'($urandom_range(0, 1));
         bus.ls_idx_i = 3'($urandom); bus.ls_dcd_bin_i = 15'($urandom); bus.ls_has_bkt_i = 1'($urandom);
         bus.ls_load_i = ($urandom_range(0, 9) == 0);
         lpat = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         bus.lvl_states_i = lpat[127:0];
         bus.clr_i = ($urandom_range(0, 39) == 0);
         rst = ($urandom_range(0, 59) == 0);
         tick();
         rst = 1'b0;
         #1;
         check_buses("rand");
         check_row("rand", int'($urandom_range(0, 7)));
         check_fields("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end
      check_all("final");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
